data_mem_arbiter: RTL

//  Shares the single-port Data memory (combinational read, posedge write) between two requesters:

---
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (combinational read,
// posedge write). Round-robin on contention, optional locked bursts capped at
// MAX_BURST beats, registered read data with a one-cycle rvalid pulse.
module data_mem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic          lock0_i,
  input  logic          lock1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_w_en_o,
  output logic [DW-1:0] mem_data_in_o,
  input  logic [DW-1:0] mem_data_out_i
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  // A burst continues only while the count before this beat is below MAX_BURST-1.
  localparam logic [CntW-1:0] CapM1 = CntW'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic            gnt_any;
  logic            sel;
  logic            sel_we;
  logic            sel_lock;
  logic [CntW-1:0] base_cnt;
  state_e          own_sel;

  // Port selection: a live owner wins outright, otherwise round-robin on ties.
  always_comb begin
    gnt_any = 1'b0;
    sel     = 1'b0;
    if (state_q == StOwn0 && req0_i) begin
      gnt_any = 1'b1;
      sel     = 1'b0;
    end else if (state_q == StOwn1 && req1_i) begin
      gnt_any = 1'b1;
      sel     = 1'b1;
    end else if (req0_i && req1_i) begin
      gnt_any = 1'b1;
      sel     = ~last_q;
    end else if (req0_i) begin
      gnt_any = 1'b1;
      sel     = 1'b0;
    end else if (req1_i) begin
      gnt_any = 1'b1;
      sel     = 1'b1;
    end
    // A request seen during reset is dropped, never performed.
    if (rst_i) gnt_any = 1'b0;
  end

  assign sel_we        = sel ? we1_i : we0_i;
  assign sel_lock      = sel ? lock1_i : lock0_i;
  assign gnt0_o        = gnt_any & ~sel;
  assign gnt1_o        = gnt_any & sel;
  assign mem_w_en_o    = gnt_any & sel_we;
  assign mem_addr_o    = (gnt_any && sel) ? addr1_i : addr0_i;
  assign mem_data_in_o = (gnt_any && sel) ? wdata1_i : wdata0_i;

  // Next-state: burst tracking, round-robin pointer and read-data capture.
  always_comb begin
    own_sel    = sel ? StOwn1 : StOwn0;
    // A new owner starts counting from zero; only a continuing owner keeps its count.
    base_cnt   = (state_q == own_sel) ? beat_cnt_q : '0;
    state_d    = StIdle;
    beat_cnt_d = '0;
    last_d     = last_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    if (gnt_any) begin
      last_d = sel;
      if (sel_lock && (base_cnt < CapM1)) begin
        state_d    = own_sel;
        beat_cnt_d = base_cnt + 1'b1;
      end
      if (!sel_we) begin
        if (sel) begin
          rdata1_d  = mem_data_out_i;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_data_out_i;
          rvalid0_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset; port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;

endmodule
